cvxif_issue_queue: RTL and testbench
====================================

# cvxif_issue_queue

Parametrised CV-X-IF coprocessor front end. Offloaded instructions are decoded against a mask/match table, and accepted instructions are buffered with their source operands in a Depth-entry FIFO. The execution unit drains the FIFO through a valid/ready port. The block sits between the CVA6 CV-X-IF issue/register interface and the coprocessor datapath. Compared with the single-cycle decoder, it adds buffering, back-pressure from the execution unit, flush, and deterministic multi-match priority.

## Interface
Parameters:
- NbInstr, 1: number of entries in the decode table.
- CoproInstr, 0: NbInstr×73-bit table; layout is defined in the package.
- NrRgprPorts, 2: 2 or 3 source-register ports.
- XLEN, 64: operand width.
- HartIdWidth, 1: width of hart id.
- IdWidth, 3: width of instruction id.
- Depth, 4: FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- flush_i  in  1  drop all buffered entries.
- issue_valid_i  in  1  offload request valid.
- issue_instr_i  in  32  instruction word.
- issue_hartid_i  in  HartIdWidth  hart id.
- issue_id_i  in  IdWidth  instruction id.
- register_valid_i  in  1  operand bundle valid.
- register_rs_i  in  NrRgprPorts×XLEN  operands; port 0 is in the LSBs.
- register_rs_valid_i  in  NrRgprPorts  per-operand valid.
- issue_ready_o  out  1  issue handshake.
- issue_accept_o  out  1  instruction accepted.
- issue_writeback_o  out  1  instruction writes rd.
- issue_register_read_o  out  NrRgprPorts  operands consumed.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  execution unit takes the head.
- out_opcode_o  out  4  head opcode.
- out_hartid_o  out  HartIdWidth  head hart id.
- out_id_o  out  IdWidth  head id.
- out_rd_o  out  5  head rd, taken from instr[11:7].
- out_registers_o  out  NrRgprPorts×XLEN  head operands; operands the entry does not read are zero.
- count_o  out  $clog2(Depth)+1  occupancy.

## Operation
Decode:
- sel[i] = (instr & mask_i) == match_i.
- Lowest matching index wins. Multiple matches are legal and carry no warning.
- No match, issue_valid_i=1: issue_ready_o=1, accept=0, writeback=0, register_read=0, no push.

Match at index i while issue_valid_i=1:
- issue_accept_o, issue_writeback_o and issue_register_read_o come from table entry i.
- If the accept bit is 0: ready=1, no push.
- Otherwise ready = ops_ok && room.
  - ops_ok = register_valid_i && every required bit of register_rs_valid_i is set. Bit 2 is ignored when NrRgprPorts=2.
  - room = (count_o<Depth) || (out_valid_o && out_ready_i).
- Push on issue_valid_i && issue_ready_o && accept=1 && !flush_i.

Push/pop:
- Push stores {opcode, hartid, id, rd, masked operands}.
- Pop on out_valid_o && out_ready_i.

Occupancy:
- count_o is incremented by push and decremented by pop.
- Simultaneous push and pop leaves count_o unchanged.
- A pop and push at full is legal; the new entry lands in the freed slot.

Other rules:
- Head outputs come from the entry at the read pointer. They are all zero when empty.
- Pointers are $clog2(Depth) bits and wrap modulo Depth.
- flush_i has priority over push and pop: pointers and count go to 0 next cycle. issue_ready_o still follows the decode rules; accepted-but-flushed requests are discarded.
- With issue_valid_i=0, all issue_* outputs are 0.

## Timing
- Issue response is combinational, same cycle as issue_valid_i.
- Push-to-visible latency is 1 cycle: the entry appears on out_* the cycle after the handshake.
- Pop is visible next cycle; the next head is presented immediately.
- Reset (rst_ni=0 at a clock edge): count_o=0, pointers=0, out_valid_o=0, out_* = 0. Issue outputs are combinational and still 0 when issue_valid_i=0.
- Reset mid-operation discards all entries; no partial state survives.
- out_* stay stable while out_valid_o && !out_ready_i.

## Structure
- Package cvxif_issue_pkg:
  - copro_instr_t layout, MSB first: instr[72:41], mask[40:9], accept[8], writeback[7], register_read[6:4], opcode[3:0].
  - opcode_t (4 bits).
- Sub-module cvxif_issue_fifo: generic Depth×width FIFO with flush and count. The top level handles decode, operand masking and handshake.

## Test plan
- NbInstr=1, match 0x0000_000B, mask 0x0000_007F, accept=1, register_read=3'b011; instr 0x0000_058B, both rs valid, out_ready_i=0 → ready=1, accept=1; next cycle out_valid_o=1, out_rd_o=11, count_o=1.
- Instr 0x0000_0033, no match → ready=1, accept=0, count unchanged.
- Same matching instr, register_rs_valid_i=2'b01 → ready=0. Setting the bit → ready=1 and push.
- Depth=4, out_ready_i=0, push 4 → count_o=4 and a 5th request gets ready=0. Assert out_ready_i in the same cycle → ready=1 and count stays 4. Drain verifies FIFO order and wrap-around.
- Two table entries both matching, opcodes 2 and 5 → accepted opcode is 2 (index 0).
- count_o=3, flush_i and a valid push in the same cycle → count_o=0 and out_valid_o=0 next cycle. rst_ni=0 mid-burst → all outputs zero next cycle.

Source files
------------

// File: rtl/cvxif_issue_pkg.sv
// Shared types for the CV-X-IF issue queue: decode-table entry layout and opcode type.
package cvxif_issue_pkg;

  localparam int unsigned CoproInstrWidth = 73;
  localparam int unsigned OpcodeWidth     = 4;

  typedef logic [OpcodeWidth-1:0] opcode_t;

  typedef struct packed {
    logic [31:0]  instr;
    logic [31:0]  mask;
    logic         accept;
    logic         writeback;
    logic [2:0]   register_read;
    opcode_t      opcode;
  } copro_instr_t;

endpackage

// File: rtl/cvxif_issue_fifo.sv
// Power-of-two FIFO with occupancy count and a flush that wins over push and pop.
module cvxif_issue_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [Width-1:0]         data_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [PtrW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A push at full is only taken when the head leaves in the same cycle.
  assign w_do_pop  = pop_i && (r_count != {(PtrW+1){1'b0}});
  assign w_do_push = push_i && ((r_count != (PtrW+1)'(Depth)) || w_do_pop);

  // Pointer and occupancy state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end else begin
        r_rptr <= r_rptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PtrW+1)'(1);
        2'b01:   r_count <= r_count - (PtrW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only observable through a valid head.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && w_do_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  assign valid_o = (r_count != {(PtrW+1){1'b0}});
  assign data_o  = valid_o ? r_mem[r_rptr] : {Width{1'b0}};
  assign count_o = r_count;

endmodule

// File: rtl/cvxif_issue_queue.sv
// CV-X-IF front end: mask/match decode with lowest-index priority, operand
// masking, and a buffered valid/ready hand-off to the execution unit.
module cvxif_issue_queue
  import cvxif_issue_pkg::*;
#(
  parameter int unsigned                         NbInstr     = 1,
  parameter logic [NbInstr*CoproInstrWidth-1:0]  CoproInstr  = '0,
  parameter int unsigned                         NrRgprPorts = 2,
  parameter int unsigned                         XLEN        = 64,
  parameter int unsigned                         HartIdWidth = 1,
  parameter int unsigned                         IdWidth     = 3,
  parameter int unsigned                         Depth       = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          issue_valid_i,
  input  logic [31:0]                   issue_instr_i,
  input  logic [HartIdWidth-1:0]        issue_hartid_i,
  input  logic [IdWidth-1:0]            issue_id_i,
  input  logic                          register_valid_i,
  input  logic [NrRgprPorts*XLEN-1:0]   register_rs_i,
  input  logic [NrRgprPorts-1:0]        register_rs_valid_i,
  output logic                          issue_ready_o,
  output logic                          issue_accept_o,
  output logic                          issue_writeback_o,
  output logic [NrRgprPorts-1:0]        issue_register_read_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [3:0]                    out_opcode_o,
  output logic [HartIdWidth-1:0]        out_hartid_o,
  output logic [IdWidth-1:0]            out_id_o,
  output logic [4:0]                    out_rd_o,
  output logic [NrRgprPorts*XLEN-1:0]   out_registers_o,
  output logic [$clog2(Depth):0]        count_o
);

  localparam int unsigned CntW   = $clog2(Depth) + 1;
  localparam int unsigned OpsW   = NrRgprPorts * XLEN;
  localparam int unsigned EntryW = OpcodeWidth + HartIdWidth + IdWidth + 5 + OpsW;

  function automatic copro_instr_t entry_at(input int unsigned idx);
    return copro_instr_t'(CoproInstr[idx*CoproInstrWidth +: CoproInstrWidth]);
  endfunction

  copro_instr_t             w_entry;
  logic                     w_hit;
  logic                     w_accept;
  logic                     w_wb;
  logic [NrRgprPorts-1:0]   w_req;
  opcode_t                  w_opcode;
  logic                     w_ops_ok;
  logic                     w_room;
  logic                     w_push;
  logic                     w_pop;
  logic [OpsW-1:0]          w_ops;
  logic [EntryW-1:0]        w_din;
  logic [EntryW-1:0]        w_dout;

  // Table scan: the first matching index is kept, later matches are ignored.
  always_comb begin
    w_entry  = '0;
    w_hit    = 1'b0;
    w_accept = 1'b0;
    w_wb     = 1'b0;
    w_req    = '0;
    w_opcode = '0;
    for (int unsigned i = 0; i < NbInstr; i++) begin
      w_entry = entry_at(i);
      if (!w_hit && ((issue_instr_i & w_entry.mask) == w_entry.instr)) begin
        w_hit    = 1'b1;
        w_accept = w_entry.accept;
        w_wb     = w_entry.writeback;
        w_req    = w_entry.register_read[NrRgprPorts-1:0];
        w_opcode = w_entry.opcode;
      end else begin
        w_hit    = w_hit;
      end
    end
  end

  assign w_pop    = out_valid_o && out_ready_i;
  assign w_ops_ok = register_valid_i && ((register_rs_valid_i & w_req) == w_req);
  assign w_room   = (count_o < CntW'(Depth)) || w_pop;

  // Issue handshake response, combinational in the request cycle.
  always_comb begin
    issue_ready_o         = 1'b0;
    issue_accept_o        = 1'b0;
    issue_writeback_o     = 1'b0;
    issue_register_read_o = '0;
    if (issue_valid_i) begin
      if (w_hit) begin
        issue_accept_o        = w_accept;
        issue_writeback_o     = w_wb;
        issue_register_read_o = w_req;
        if (w_accept) begin
          issue_ready_o = w_ops_ok && w_room;
        end else begin
          issue_ready_o = 1'b1;
        end
      end else begin
        issue_ready_o = 1'b1;
      end
    end else begin
      issue_ready_o = 1'b0;
    end
  end

  assign w_push = issue_valid_i && issue_ready_o && w_hit && w_accept && !flush_i;

  // Operands the instruction does not read are stored as zero.
  always_comb begin
    w_ops = '0;
    for (int unsigned p = 0; p < NrRgprPorts; p++) begin
      if (w_req[p]) begin
        w_ops[p*XLEN +: XLEN] = register_rs_i[p*XLEN +: XLEN];
      end else begin
        w_ops[p*XLEN +: XLEN] = '0;
      end
    end
  end

  assign w_din = {w_opcode, issue_hartid_i, issue_id_i, issue_instr_i[11:7], w_ops};

  cvxif_issue_fifo #(
    .Depth (Depth),
    .Width (EntryW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_push),
    .data_i  (w_din),
    .pop_i   (w_pop),
    .valid_o (out_valid_o),
    .data_o  (w_dout),
    .count_o (count_o)
  );

  assign {out_opcode_o, out_hartid_o, out_id_o, out_rd_o, out_registers_o} = w_dout;

endmodule

// File: tb/tb_cvxif_issue_queue.sv
// Self-checking bench for cvxif_issue_queue: decode vector table plus scoreboarded FIFO sequences.
module tb_cvxif_issue_queue;
  import cvxif_issue_pkg::*;

  localparam int unsigned NB = 3;
  localparam int unsigned NR = 2;
  localparam int unsigned XL = 64;
  localparam int unsigned HW = 1;
  localparam int unsigned IW = 3;
  localparam int unsigned DP = 4;

  // {match, mask, accept, writeback, register_read, opcode}
  localparam logic [72:0] E0 = {32'h0000_000B, 32'h0000_707F, 1'b1, 1'b1, 3'b011, 4'd2};
  localparam logic [72:0] E1 = {32'h0000_000B, 32'h0000_007F, 1'b1, 1'b0, 3'b001, 4'd5};
  localparam logic [72:0] E2 = {32'h0000_002B, 32'h0000_007F, 1'b0, 1'b1, 3'b000, 4'd7};

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  logic              issue_valid_i;
  logic [31:0]       issue_instr_i;
  logic [HW-1:0]     issue_hartid_i;
  logic [IW-1:0]     issue_id_i;
  logic              register_valid_i;
  logic [NR*XL-1:0]  register_rs_i;
  logic [NR-1:0]     register_rs_valid_i;
  logic              issue_ready_o;
  logic              issue_accept_o;
  logic              issue_writeback_o;
  logic [NR-1:0]     issue_register_read_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [3:0]        out_opcode_o;
  logic [HW-1:0]     out_hartid_o;
  logic [IW-1:0]     out_id_o;
  logic [4:0]        out_rd_o;
  logic [NR*XL-1:0]  out_registers_o;
  logic [$clog2(DP):0] count_o;

  cvxif_issue_queue #(
    .NbInstr(NB), .CoproInstr({E2, E1, E0}), .NrRgprPorts(NR), .XLEN(XL),
    .HartIdWidth(HW), .IdWidth(IW), .Depth(DP)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_instr_i(issue_instr_i),
    .issue_hartid_i(issue_hartid_i), .issue_id_i(issue_id_i),
    .register_valid_i(register_valid_i), .register_rs_i(register_rs_i),
    .register_rs_valid_i(register_rs_valid_i),
    .issue_ready_o(issue_ready_o), .issue_accept_o(issue_accept_o),
    .issue_writeback_o(issue_writeback_o), .issue_register_read_o(issue_register_read_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_opcode_o(out_opcode_o),
    .out_hartid_o(out_hartid_o), .out_id_o(out_id_o), .out_rd_o(out_rd_o),
    .out_registers_o(out_registers_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]       op;
    logic [HW-1:0]    hid;
    logic [IW-1:0]    id;
    logic [4:0]       rd;
    logic [NR*XL-1:0] regs;
  } item_t;

  typedef struct {
    logic        v;
    logic        rv;
    logic [31:0] instr;
    logic [1:0]  rsv;
    logic        rdy;
    logic        acc;
    logic        wb;
    logic [1:0]  rr;
  } vec_t;

  item_t sb[$];
  item_t exp_item;
  logic  exp_push;
  int    n_cmp;
  int    n_fail;
  vec_t  vt[10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Head must equal the oldest scoreboard entry, or all zero when the model is empty.
  task automatic check_head();
    chk("count", 128'(count_o), 128'(sb.size()));
    if (sb.size() == 0) begin
      chk("head_valid_empty", 128'(out_valid_o), 128'(0));
      chk("head_op_empty", 128'(out_opcode_o), 128'(0));
      chk("head_rd_empty", 128'(out_rd_o), 128'(0));
      chk("head_regs_empty", 128'(out_registers_o), 128'(0));
    end else begin
      chk("head_valid", 128'(out_valid_o), 128'(1));
      chk("head_op", 128'(out_opcode_o), 128'(sb[0].op));
      chk("head_hartid", 128'(out_hartid_o), 128'(sb[0].hid));
      chk("head_id", 128'(out_id_o), 128'(sb[0].id));
      chk("head_rd", 128'(out_rd_o), 128'(sb[0].rd));
      chk("head_regs", 128'(out_registers_o), 128'(sb[0].regs));
    end
  endtask

  task automatic tick();
    #2;
    check_head();
    if (out_ready_i && sb.size() > 0) void'(sb.pop_front());
    if (exp_push) sb.push_back(exp_item);
    if (flush_i || !rst_ni) sb.delete();
    @(posedge clk_i);
    #1;
    exp_push = 1'b0;
  endtask

  task automatic offer(input string nm, input logic [31:0] instr, input logic [1:0] rsv,
                       input logic erdy, input logic eacc, input logic ewb,
                       input logic [1:0] err, input logic [3:0] eop);
    issue_valid_i       = 1'b1;
    issue_instr_i       = instr;
    issue_hartid_i      = issue_hartid_i + HW'(1);
    issue_id_i          = issue_id_i + IW'(1);
    register_valid_i    = 1'b1;
    register_rs_i       = {$urandom, $urandom, $urandom, $urandom};
    register_rs_valid_i = rsv;
    #2;
    chk({nm, "_ready"}, 128'(issue_ready_o), 128'(erdy));
    chk({nm, "_accept"}, 128'(issue_accept_o), 128'(eacc));
    chk({nm, "_wb"}, 128'(issue_writeback_o), 128'(ewb));
    chk({nm, "_rr"}, 128'(issue_register_read_o), 128'(err));
    exp_item.op   = eop;
    exp_item.hid  = issue_hartid_i;
    exp_item.id   = issue_id_i;
    exp_item.rd   = instr[11:7];
    exp_item.regs = {err[1] ? register_rs_i[127:64] : 64'd0, err[0] ? register_rs_i[63:0] : 64'd0};
    exp_push      = erdy && eacc && !flush_i;
    tick();
    issue_valid_i = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; exp_push = 1'b0; exp_item = '0;
    rst_ni = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0; issue_instr_i = 32'd0;
    issue_hartid_i = '0; issue_id_i = '0; register_valid_i = 1'b0;
    register_rs_i = '0; register_rs_valid_i = 2'b00; out_ready_i = 1'b0;

    //          v     rv    instr          rsv    rdy   acc   wb    rr
    vt[0] = '{1'b0, 1'b1, 32'h0000_058B, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00};
    vt[1] = '{1'b1, 1'b1, 32'h0000_058B, 2'b11, 1'b1, 1'b1, 1'b1, 2'b11};
    vt[2] = '{1'b1, 1'b1, 32'h0000_058B, 2'b01, 1'b0, 1'b1, 1'b1, 2'b11};
    vt[3] = '{1'b1, 1'b0, 32'h0000_058B, 2'b11, 1'b0, 1'b1, 1'b1, 2'b11};
    vt[4] = '{1'b1, 1'b1, 32'h0000_458B, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01};
    vt[5] = '{1'b1, 1'b1, 32'h0000_458B, 2'b10, 1'b0, 1'b1, 1'b0, 2'b01};
    vt[6] = '{1'b1, 1'b1, 32'h0000_0033, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[7] = '{1'b1, 1'b0, 32'h0000_002B, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00};
    vt[8] = '{1'b1, 1'b1, 32'h0000_000F, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[9] = '{1'b1, 1'b1, 32'hFFFF_F00B, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01};

    @(posedge clk_i);
    #1;
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
    chk("rst_ready", 128'(issue_ready_o), 128'(0));
    chk("rst_accept", 128'(issue_accept_o), 128'(0));
    chk("rst_count", 128'(count_o), 128'(0));
    chk("rst_valid", 128'(out_valid_o), 128'(0));
    tick();

    // Decode vectors; flush keeps the FIFO empty so only the issue response matters.
    flush_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      issue_valid_i       = vt[k].v;
      register_valid_i    = vt[k].rv;
      issue_instr_i       = vt[k].instr;
      register_rs_valid_i = vt[k].rsv;
      register_rs_i       = {$urandom, $urandom, $urandom, $urandom};
      #2;
      chk($sformatf("vec%0d_ready", k), 128'(issue_ready_o), 128'(vt[k].rdy));
      chk($sformatf("vec%0d_accept", k), 128'(issue_accept_o), 128'(vt[k].acc));
      chk($sformatf("vec%0d_wb", k), 128'(issue_writeback_o), 128'(vt[k].wb));
      chk($sformatf("vec%0d_rr", k), 128'(issue_register_read_o), 128'(vt[k].rr));
      tick();
    end
    flush_i = 1'b0;
    issue_valid_i = 1'b0;
    tick();

    // First push: visible next cycle with rd=11 and multi-match opcode 2.
    offer("push1", 32'h0000_058B, 2'b11, 1'b1, 1'b1, 1'b1, 2'b11, 4'd2);
    chk("push1_valid", 128'(out_valid_o), 128'(1));
    chk("push1_rd", 128'(out_rd_o), 128'(11));
    chk("push1_count", 128'(count_o), 128'(1));
    chk("prio_opcode", 128'(out_opcode_o), 128'(2));
    offer("nomatch", 32'h0000_0033, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0);
    chk("nomatch_count", 128'(count_o), 128'(1));
    offer("opsmiss", 32'h0000_058B, 2'b01, 1'b0, 1'b1, 1'b1, 2'b11, 4'd2);
    offer("opsok", 32'h0000_058B, 2'b11, 1'b1, 1'b1, 1'b1, 2'b11, 4'd2);
    offer("e1a", 32'h0000_458B, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 4'd5);
    offer("e1b", 32'hFFFF_F00B, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 4'd5);
    chk("full_count", 128'(count_o), 128'(4));
    offer("full", 32'h0000_058B, 2'b11, 1'b0, 1'b1, 1'b1, 2'b11, 4'd2);
    out_ready_i = 1'b1;
    offer("fullpop", 32'h0000_0D0B, 2'b11, 1'b1, 1'b1, 1'b1, 2'b11, 4'd2);
    chk("fullpop_count", 128'(count_o), 128'(4));
    issue_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("drain_count", 128'(count_o), 128'(0));

    // Flush with a simultaneous accepted request.
    out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) offer("fl_push", 32'h0000_458B, 2'b11, 1'b1, 1'b1, 1'b0, 2'b01, 4'd5);
    chk("fl_count3", 128'(count_o), 128'(3));
    flush_i = 1'b1;
    offer("fl_req", 32'h0000_058B, 2'b11, 1'b1, 1'b1, 1'b1, 2'b11, 4'd2);
    flush_i = 1'b0;
    chk("fl_count", 128'(count_o), 128'(0));
    chk("fl_valid", 128'(out_valid_o), 128'(0));

    // Reset in the middle of a burst.
    offer("rb1", 32'h0000_058B, 2'b11, 1'b1, 1'b1, 1'b1, 2'b11, 4'd2);
    offer("rb2", 32'h0000_458B, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 4'd5);
    rst_ni = 1'b0;
    offer("rb3", 32'h0000_058B, 2'b11, 1'b1, 1'b1, 1'b1, 2'b11, 4'd2);
    rst_ni = 1'b1;
    chk("mrst_count", 128'(count_o), 128'(0));
    chk("mrst_valid", 128'(out_valid_o), 128'(0));
    chk("mrst_op", 128'(out_opcode_o), 128'(0));
    chk("mrst_rd", 128'(out_rd_o), 128'(0));
    chk("mrst_regs", 128'(out_registers_o), 128'(0));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
